ram4k_block_reader: RTL and testbench

- Sequential read master for the RAM4k array: on a start command it walks a contiguous address range and presents each word on a valid/ready output stream.
- Read-side counterpart to the load/sel write path. Drives RAM4k sel with load held low, samples RAM4k out, and accumulates a 16-bit additive checksum of the words delivered.
- Sits between RAM4k and any downstream consumer, for example a display or serial transmitter.

---
 rtl/ram4k_block_reader.sv | 127 ++++++++++++
 tb/tb_ram4k_block_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4k_block_reader.sv
// Sequential read master for RAM4k: walks an address range and streams
// each word over valid/ready while accumulating a 16-bit checksum.
module ram4k_block_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_sel,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic [DATA_W-1:0] r_sum;

  state_t            w_state_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic [ADDR_W:0]   w_rem_n;
  logic [DATA_W-1:0] w_data_n;
  logic              w_valid_n;
  logic              w_last_n;
  logic [DATA_W-1:0] w_sum_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_rem   <= w_rem_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_last  <= w_last_n;
      r_sum   <= w_sum_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_rem_n   = r_rem;
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_last_n  = r_last;
    w_sum_n   = r_sum;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sum_n = '0;
          if (length != '0) begin
            w_addr_n  = base_addr;
            w_rem_n   = length;
            w_state_n = S_FETCH;
          end else begin
            w_state_n = S_DONE;
          end
        end
      end
      S_FETCH: begin
        w_data_n  = mem_out;
        w_valid_n = 1'b1;
        w_last_n  = (r_rem == (ADDR_W+1)'(1));
        w_state_n = S_SEND;
      end
      S_SEND: begin
        if (rd_ready) begin
          w_sum_n   = r_sum + r_data;
          w_valid_n = 1'b0;
          w_last_n  = 1'b0;
          if (r_last) begin
            w_state_n = S_DONE;
          end else begin
            // addr wraps naturally at the top of the array
            w_addr_n  = r_addr + 1'b1;
            w_rem_n   = r_rem - 1'b1;
            w_state_n = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign busy     = (r_state == S_FETCH) || (r_state == S_SEND);
  assign done     = (r_state == S_DONE);
  assign checksum = r_sum;
  assign mem_sel  = r_addr;
  assign mem_load = 1'b0;
  assign rd_data  = r_data;
  assign rd_valid = r_valid;
  assign rd_last  = r_last;

endmodule

// File: tb/tb_ram4k_block_reader.sv
// Directed bench for ram4k_block_reader with a behavioural RAM4k
// and hand-computed expected streams and checksums.
module tb_ram4k_block_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [11:0] mem_sel;
  logic        mem_load;
  logic [15:0] mem_out;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;

  logic [15:0] ram [0:4095];

  int n_chk;
  int n_fail;
  int done_cnt;
  int busy_seen;
  int valid_seen;
  int load_seen;

  logic [15:0] words [$];
  logic [11:0] sels [$];
  logic [31:0] lastbits;
  int          nstall;
  int          stall_bad;

  ram4k_block_reader #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .checksum(checksum),
    .mem_sel(mem_sel),
    .mem_load(mem_load),
    .mem_out(mem_out),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_last(rd_last)
  );

  assign mem_out = ram[mem_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_seen++;
    if (rd_valid) valid_seen++;
    if (mem_load !== 1'b0) load_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    done_cnt   = 0;
    busy_seen  = 0;
    valid_seen = 0;
  endtask

  task automatic run(input logic [11:0] b, input logic [12:0] n,
                     input int stall, input bit inj);
    logic [15:0] hold_d;
    logic [11:0] hold_s;
    words.delete();
    sels.delete();
    lastbits  = '0;
    nstall    = 0;
    stall_bad = 0;
    hold_d    = '0;
    hold_s    = '0;
    start     = 1'b1;
    base_addr = b;
    length    = n;
    rd_ready  = (stall == 0);
    tick();
    start = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (inj && c == 2) begin
        start     = 1'b1;
        base_addr = 12'h100;
        length    = 13'd1;
      end else if (inj && c == 3) begin
        start = 1'b0;
      end
      if (busy && !rd_valid) sels.push_back(mem_sel);
      if (rd_valid) begin
        if (nstall < stall) begin
          if (nstall == 0) begin
            hold_d = rd_data;
            hold_s = mem_sel;
          end else if (rd_data !== hold_d || mem_sel !== hold_s) begin
            stall_bad++;
          end
          nstall++;
        end else begin
          rd_ready = 1'b1;
          lastbits[words.size()] = rd_last;
          words.push_back(rd_data);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    load_seen = 0;
    clr_mon();
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    rd_ready  = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_sel", mem_sel, 0);
    reset = 1'b0;
    tick();

    ram[12'h958] = 16'hF00D;
    ram[12'h959] = 16'hDEAF;
    ram[12'h100] = 16'hAAAA;

    clr_mon();
    run(12'h958, 13'd2, 0, 0);
    chk("t1_done", done, 1);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_nwords", words.size(), 2);
    chk("t1_w0", words[0], 16'hF00D);
    chk("t1_w1", words[1], 16'hDEAF);
    chk("t1_last", lastbits, 32'h2);
    chk("t1_sel0", sels[0], 12'h958);
    chk("t1_sel1", sels[1], 12'h959);
    chk("t1_sum", checksum, 16'hCEBC);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_sum_held", checksum, 16'hCEBC);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_cycles", busy_seen, 4);

    clr_mon();
    run(12'h958, 13'd2, 5, 0);
    chk("t2_done", done, 1);
    chk("t2_stall_cycles", nstall, 5);
    chk("t2_stall_stable", stall_bad, 0);
    chk("t2_nwords", words.size(), 2);
    chk("t2_w0", words[0], 16'hF00D);
    chk("t2_w1", words[1], 16'hDEAF);
    chk("t2_nsel", sels.size(), 2);
    chk("t2_sum", checksum, 16'hCEBC);
    tick();

    ram[12'hFFF] = 16'h0001;
    ram[12'h000] = 16'h0002;
    ram[12'h001] = 16'h0003;
    clr_mon();
    run(12'hFFF, 13'd3, 0, 0);
    chk("t3_done", done, 1);
    chk("t3_nsel", sels.size(), 3);
    chk("t3_sel0", sels[0], 12'hFFF);
    chk("t3_sel1", sels[1], 12'h000);
    chk("t3_sel2", sels[2], 12'h001);
    chk("t3_last", lastbits, 32'h4);
    chk("t3_sum", checksum, 16'h0006);
    tick();

    clr_mon();
    run(12'h123, 13'd0, 0, 0);
    chk("t4_done", done, 1);
    chk("t4_sum", checksum, 16'h0000);
    tick();
    chk("t4_done_pulse", done, 0);
    chk("t4_busy_seen", busy_seen, 0);
    chk("t4_valid_seen", valid_seen, 0);

    ram[12'h000] = 16'h1111;
    ram[12'h001] = 16'h2222;
    ram[12'h002] = 16'h3333;
    ram[12'h003] = 16'h4444;
    clr_mon();
    start     = 1'b1;
    base_addr = 12'h000;
    length    = 13'd4;
    rd_ready  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_pre_valid", rd_valid, 1);
    chk("t5_pre_data", rd_data, 16'h2222);
    chk("t5_pre_sum", checksum, 16'h1111);
    reset = 1'b1;
    tick();
    chk("t5_valid", rd_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_sum", checksum, 0);
    chk("t5_done", done, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("t5_no_done", done_cnt, 0);
    run(12'h000, 13'd1, 0, 0);
    chk("t5b_done", done, 1);
    chk("t5b_nwords", words.size(), 1);
    chk("t5b_w0", words[0], 16'h1111);
    chk("t5b_last", lastbits, 32'h1);
    chk("t5b_sum", checksum, 16'h1111);
    tick();

    clr_mon();
    run(12'h958, 13'd2, 0, 1);
    chk("t6_done", done, 1);
    start     = 1'b1;
    base_addr = 12'h100;
    length    = 13'd1;
    tick();
    start = 1'b0;
    chk("t6_done_ignore", busy, 0);
    chk("t6_nwords", words.size(), 2);
    chk("t6_w0", words[0], 16'hF00D);
    chk("t6_w1", words[1], 16'hDEAF);
    chk("t6_sum", checksum, 16'hCEBC);
    tick();
    tick();
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_busy_after", busy, 0);

    chk("mem_load_never", load_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
